// File: rtl/sdram_pkg.sv
// Shared definitions for the SDR SDRAM device emulator: command encodings,
// mode-register field positions, protocol-error codes and burst-length decode.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_LOAD_MODE    = 3'b000,
        CMD_AUTO_REFRESH = 3'b001,
        CMD_PRECHARGE    = 3'b010,
        CMD_ACTIVE       = 3'b011,
        CMD_WRITE        = 3'b100,
        CMD_READ         = 3'b101,
        CMD_BURST_TERM   = 3'b110,
        CMD_NOP          = 3'b111
    } sdram_cmd_e;

    localparam int MODE_BL_LSB = 0;
    localparam int MODE_BT_BIT = 3;
    localparam int MODE_CL_LSB = 4;
    localparam int MODE_WB_BIT = 9;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_CLOSED     = 3'd1;
    localparam logic [2:0] ERR_ACT_OPEN   = 3'd2;
    localparam logic [2:0] ERR_BANK_OPEN  = 3'd3;
    localparam logic [2:0] ERR_TRCD       = 3'd4;

    // Index of the last beat for a mode BL field; reserved codes act as BL=1.
    function automatic logic [2:0] bl_last(input logic [2:0] bl);
        case (bl)
            3'd1:    return 3'd1;
            3'd2:    return 3'd3;
            3'd3:    return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/sdram_emu_mem.sv
// Backing store for the SDRAM emulator: 2**AW x 32 words, one byte-enabled
// synchronous write port and one asynchronous read port.
module sdram_emu_mem #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_q [0:(2**AW)-1];

    // Byte-lane write port.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && be[b]) begin
                mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sdram_emu.sv
// SDR SDRAM device emulator (responder side of the command bus).
// Define SDRAM_EMU_CHECK_EN to build the tRCD counters and the sticky protocol checker.
module sdram_emu
    import sdram_pkg::*;
#(
    parameter int          MEM_AW    = 12,
    parameter int          ROW_BITS  = 11,
    parameter int          COL_BITS  = 8,
    parameter int          TRCD      = 1,
    parameter logic [12:0] INIT_MODE = 13'h220
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_cs,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    input  logic [1:0]  sd_ba,
    input  logic [12:0] sd_addr,
    input  logic [3:0]  sd_dqm,
    input  logic [31:0] sd_dq_i,
    output logic [31:0] sd_dq_o,
    output logic [3:0]  sd_dq_oe,
    output logic [12:0] mode_reg,
    output logic [15:0] refresh_count,
    output logic        err,
    output logic [2:0]  err_code
);

    sdram_cmd_e                    cmd_s;
    logic                          rw_s, acc_s, trunc_s, cl3_s, out_vld_s;
    logic                          issue_vld_s, issue_wr_s, mem_we_s, ap_close_s;
    logic [1:0]                    ap_bank_s;
    logic [2:0]                    new_last_s;
    logic [MEM_AW-1:0]             issue_addr_s, rd_addr_s;
    logic [31:0]                   rd_data_s;

    logic [3:0]                    open_q, open_d;
    logic [3:0][ROW_BITS-1:0]      row_q, row_d;
    logic [12:0]                   mode_q, mode_d;
    logic [15:0]                   refresh_q, refresh_d;
    logic                          bst_act_q, bst_act_d, bst_wr_q, bst_wr_d;
    logic                          bst_il_q, bst_il_d, bst_ap_q, bst_ap_d;
    logic [1:0]                    bst_ba_q, bst_ba_d;
    logic [COL_BITS-1:0]           bst_col_q, bst_col_d;
    logic [2:0]                    bst_idx_q, bst_idx_d, bst_last_q, bst_last_d;
    logic                          p1_vld_q, p1_vld_d, p1_cl3_q, p1_cl3_d, p2_vld_q, p2_vld_d;
    logic [MEM_AW-1:0]             p1_addr_q, p1_addr_d, p2_addr_q, p2_addr_d;
    logic [3:0]                    dqm_q, dqm_d, dq_oe_q, dq_oe_d;
    logic [31:0]                   dq_o_q, dq_o_d;

    // Column of a burst beat: sequential wraps inside the BL-aligned block, interleaved XORs.
    function automatic logic [COL_BITS-1:0] beat_col(input logic [COL_BITS-1:0] start,
                                                     input logic [2:0] idx,
                                                     input logic [2:0] last,
                                                     input logic il);
        logic [COL_BITS-1:0] mask, ofs;
        mask = COL_BITS'(last);
        ofs  = COL_BITS'(idx);
        return (start & ~mask) | ((il ? (start ^ ofs) : (start + ofs)) & mask);
    endfunction

    // Command decode and truncation detection.
    always_comb begin
        cmd_s      = sd_cs ? CMD_NOP : sdram_cmd_e'({sd_ras, sd_cas, sd_we});
        cl3_s      = (mode_q[MODE_CL_LSB +: 3] == 3'd3);
        rw_s       = (cmd_s == CMD_READ) || (cmd_s == CMD_WRITE);
        acc_s      = rw_s && open_q[sd_ba];
        trunc_s    = acc_s || (cmd_s == CMD_BURST_TERM) ||
                     ((cmd_s == CMD_PRECHARGE) && (sd_addr[10] || (sd_ba == bst_ba_q)));
        new_last_s = ((cmd_s == CMD_WRITE) && mode_q[MODE_WB_BIT]) ? 3'd0
                                                                    : bl_last(mode_q[MODE_BL_LSB +: 3]);
    end

    // Burst sequencer: picks the beat issued this cycle (new command or continuation).
    always_comb begin
        bst_act_d    = bst_act_q;
        bst_wr_d     = bst_wr_q;
        bst_il_d     = bst_il_q;
        bst_ap_d     = bst_ap_q;
        bst_ba_d     = bst_ba_q;
        bst_col_d    = bst_col_q;
        bst_idx_d    = bst_idx_q;
        bst_last_d   = bst_last_q;
        issue_vld_s  = 1'b0;
        issue_wr_s   = 1'b0;
        issue_addr_s = {MEM_AW{1'b0}};
        ap_close_s   = 1'b0;
        ap_bank_s    = bst_ba_q;
        if (acc_s) begin
            issue_vld_s  = 1'b1;
            issue_wr_s   = (cmd_s == CMD_WRITE);
            issue_addr_s = MEM_AW'({sd_ba, row_q[sd_ba], sd_addr[COL_BITS-1:0]});
            bst_act_d    = (new_last_s != 3'd0);
            bst_wr_d     = (cmd_s == CMD_WRITE);
            bst_il_d     = mode_q[MODE_BT_BIT];
            bst_ap_d     = sd_addr[10];
            bst_ba_d     = sd_ba;
            bst_col_d    = sd_addr[COL_BITS-1:0];
            bst_idx_d    = 3'd1;
            bst_last_d   = new_last_s;
            ap_close_s   = sd_addr[10] && (new_last_s == 3'd0);
            ap_bank_s    = sd_ba;
        end else if (bst_act_q && !trunc_s) begin
            issue_vld_s  = 1'b1;
            issue_wr_s   = bst_wr_q;
            issue_addr_s = MEM_AW'({bst_ba_q, row_q[bst_ba_q],
                                    beat_col(bst_col_q, bst_idx_q, bst_last_q, bst_il_q)});
            bst_idx_d    = bst_idx_q + 3'd1;
            if (bst_idx_q == bst_last_q) begin
                bst_act_d  = 1'b0;
                ap_close_s = bst_ap_q;
            end else begin
                bst_act_d  = 1'b1;
            end
        end else if (trunc_s) begin
            bst_act_d = 1'b0;
        end else begin
            bst_act_d = bst_act_q;
        end
    end

    // Read-data pipeline: one stage for CL=2, two for CL=3; DQM applied with two-cycle latency.
    always_comb begin
        mem_we_s  = issue_vld_s && issue_wr_s;
        p1_vld_d  = issue_vld_s && !issue_wr_s;
        p1_addr_d = issue_addr_s;
        p1_cl3_d  = cl3_s;
        p2_vld_d  = p1_vld_q && p1_cl3_q && !trunc_s;
        p2_addr_d = p1_addr_q;
        out_vld_s = (p2_vld_q || (p1_vld_q && !p1_cl3_q)) && !trunc_s;
        rd_addr_s = p2_vld_q ? p2_addr_q : p1_addr_q;
        dqm_d     = sd_dqm;
        dq_oe_d   = out_vld_s ? ~dqm_q : 4'h0;
        dq_o_d    = 32'h0000_0000;
        for (int b = 0; b < 4; b++) begin
            dq_o_d[8*b +: 8] = dq_oe_d[b] ? rd_data_s[8*b +: 8] : 8'h00;
        end
    end

    // Bank state, mode register and refresh counter.
    always_comb begin
        open_d    = open_q;
        row_d     = row_q;
        mode_d    = mode_q;
        refresh_d = refresh_q;
        if (ap_close_s) begin
            open_d[ap_bank_s] = 1'b0;
        end else begin
            open_d = open_q;
        end
        case (cmd_s)
            CMD_ACTIVE: begin
                open_d[sd_ba] = 1'b1;
                row_d[sd_ba]  = sd_addr[ROW_BITS-1:0];
            end
            CMD_PRECHARGE: begin
                if (sd_addr[10]) begin
                    open_d = 4'h0;
                end else begin
                    open_d[sd_ba] = 1'b0;
                end
            end
            CMD_LOAD_MODE:    mode_d    = sd_addr;
            CMD_AUTO_REFRESH: refresh_d = refresh_q + 16'd1;
            default:          mode_d    = mode_q;
        endcase
    end

    // Datapath and control registers; the backing store is deliberately not reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            open_q     <= 4'h0;
            row_q      <= '0;
            mode_q     <= INIT_MODE;
            refresh_q  <= 16'd0;
            bst_act_q  <= 1'b0;
            bst_wr_q   <= 1'b0;
            bst_il_q   <= 1'b0;
            bst_ap_q   <= 1'b0;
            bst_ba_q   <= 2'd0;
            bst_col_q  <= {COL_BITS{1'b0}};
            bst_idx_q  <= 3'd0;
            bst_last_q <= 3'd0;
            p1_vld_q   <= 1'b0;
            p1_cl3_q   <= 1'b0;
            p1_addr_q  <= {MEM_AW{1'b0}};
            p2_vld_q   <= 1'b0;
            p2_addr_q  <= {MEM_AW{1'b0}};
            dqm_q      <= 4'h0;
            dq_oe_q    <= 4'h0;
            dq_o_q     <= 32'h0000_0000;
        end else begin
            open_q     <= open_d;
            row_q      <= row_d;
            mode_q     <= mode_d;
            refresh_q  <= refresh_d;
            bst_act_q  <= bst_act_d;
            bst_wr_q   <= bst_wr_d;
            bst_il_q   <= bst_il_d;
            bst_ap_q   <= bst_ap_d;
            bst_ba_q   <= bst_ba_d;
            bst_col_q  <= bst_col_d;
            bst_idx_q  <= bst_idx_d;
            bst_last_q <= bst_last_d;
            p1_vld_q   <= p1_vld_d;
            p1_cl3_q   <= p1_cl3_d;
            p1_addr_q  <= p1_addr_d;
            p2_vld_q   <= p2_vld_d;
            p2_addr_q  <= p2_addr_d;
            dqm_q      <= dqm_d;
            dq_oe_q    <= dq_oe_d;
            dq_o_q     <= dq_o_d;
        end
    end

    sdram_emu_mem #(.AW(MEM_AW)) u_mem (
        .clk     (clk),
        .we      (mem_we_s),
        .be      (~sd_dqm),
        .wr_addr (issue_addr_s),
        .wr_data (sd_dq_i),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    assign sd_dq_o       = dq_o_q;
    assign sd_dq_oe      = dq_oe_q;
    assign mode_reg      = mode_q;
    assign refresh_count = refresh_q;

`ifdef SDRAM_EMU_CHECK_EN
    logic [3:0][3:0] trcd_q, trcd_d;
    logic            err_q, err_d;
    logic [2:0]      err_code_q, err_code_d, hit_code_s;

    // tRCD down-counters and first-error capture; a counter above 1 means ACTIVE is too recent.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            trcd_d[b] = (trcd_q[b] != 4'd0) ? (trcd_q[b] - 4'd1) : 4'd0;
        end
        if (cmd_s == CMD_ACTIVE) begin
            trcd_d[sd_ba] = 4'(TRCD);
        end else begin
            trcd_d[sd_ba] = trcd_d[sd_ba];
        end
        if (rw_s && !open_q[sd_ba]) begin
            hit_code_s = ERR_CLOSED;
        end else if ((cmd_s == CMD_ACTIVE) && open_q[sd_ba]) begin
            hit_code_s = ERR_ACT_OPEN;
        end else if (((cmd_s == CMD_AUTO_REFRESH) || (cmd_s == CMD_LOAD_MODE)) && (open_q != 4'h0)) begin
            hit_code_s = ERR_BANK_OPEN;
        end else if (rw_s && (trcd_q[sd_ba] > 4'd1)) begin
            hit_code_s = ERR_TRCD;
        end else begin
            hit_code_s = ERR_NONE;
        end
        if (!err_q && (hit_code_s != ERR_NONE)) begin
            err_d      = 1'b1;
            err_code_d = hit_code_s;
        end else begin
            err_d      = err_q;
            err_code_d = err_code_q;
        end
    end

    // Checker registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            trcd_q     <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            trcd_q     <= trcd_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;
`else
    assign err      = 1'b0;
    assign err_code = ERR_NONE;
`endif

endmodule
